// File: rtl/arith_divider_pkg.sv
// Shared arithmetic types: adder mode select and divider state encoding.
package arith_divider_pkg;

    typedef enum logic {
        ARITH_ADD = 1'b0,
        ARITH_SUB = 1'b1
    } Arith_AddSub_T;

    typedef logic [1:0] Arith_Divider_State_T;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;

endpackage

// File: rtl/Arith_addSubtract.sv
// Combinational adder/subtractor; status is the carry out (no-borrow in subtract mode).
module Arith_addSubtract
    import arith_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  Arith_AddSub_T    mode,
    output logic [WIDTH-1:0] result,
    output logic             status
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             carry_in;

    // Subtraction is a + ~b + 1.
    assign carry_in = (mode == ARITH_SUB);
    assign b_eff    = carry_in ? ~b : b;
    assign sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
    assign result   = sum[WIDTH-1:0];
    assign status   = sum[WIDTH];

endmodule

// File: rtl/arith_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle, sign fix-up at the end.
module arith_divider
    import arith_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    Arith_Divider_State_T state;
    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     part_rem;
    logic [WIDTH-1:0]     quot_reg;
    logic [WIDTH-1:0]     div_mag;
    logic                 neg_q;
    logic                 neg_r;
    logic                 dz_pending;

    logic [WIDTH:0]       p_shift;
    logic [WIDTH:0]       trial;
    logic                 trial_carry_unused;
    logic [WIDTH-1:0]     dividend_mag;
    logic [WIDTH-1:0]     divisor_mag;
    logic                 divisor_zero;

    assign busy = (state != DIV_IDLE);

    assign divisor_zero = (divisor == '0);
    assign dividend_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_mag  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Partial remainder stays below the divisor after each step, so only the
    // shifted value needs the extra bit.
    assign p_shift = {part_rem, quot_reg[WIDTH-1]};

    Arith_addSubtract #(
        .WIDTH(WIDTH + 1)
    ) u_trial_sub (
        .a      (p_shift),
        .b      ({1'b0, div_mag}),
        .mode   (ARITH_SUB),
        .result (trial),
        .status (trial_carry_unused)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= DIV_IDLE;
            count      <= '0;
            part_rem   <= '0;
            quot_reg   <= '0;
            div_mag    <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dz_pending <= 1'b0;
            done       <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
            div_zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        count      <= '0;
                        part_rem   <= '0;
                        div_mag    <= divisor_mag;
                        dz_pending <= divisor_zero;
                        neg_q      <= signed_op && !divisor_zero && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r      <= signed_op && !divisor_zero && dividend[WIDTH-1];
                        // On divide by zero the raw dividend is parked here for the remainder.
                        quot_reg   <= divisor_zero ? dividend : dividend_mag;
                        state      <= divisor_zero ? DIV_FIX : DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    if (!trial[WIDTH]) begin
                        part_rem <= trial[WIDTH-1:0];
                        quot_reg <= {quot_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        part_rem <= p_shift[WIDTH-1:0];
                        quot_reg <= {quot_reg[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    if (dz_pending) begin
                        quotient  <= '1;
                        remainder <= quot_reg;
                    end else begin
                        quotient  <= neg_q ? -quot_reg : quot_reg;
                        remainder <= neg_r ? -part_rem : part_rem;
                    end
                    div_zero <= dz_pending;
                    done     <= 1'b1;
                    state    <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_divider.sv
// Directed bench for arith_divider with hand-computed quotients, remainders and latencies.
module tb_arith_divider;

    logic        clock;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int tests_run = 0;
    int tests_failed = 0;

    arith_divider #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one start pulse; returns #1 after the accepting edge.
    task automatic drive_start(input logic sd, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        signed_op = sd;
        dividend  = a;
        divisor   = b;
        @(posedge clock);
        #1;
        start     = 1'b0;
        signed_op = 1'($urandom_range(0, 1));
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    // Counts edges until done is seen (bounded), and post-edge samples with busy high.
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input int elat);
        int lat;
        int busy_n;
        drive_start(sd, a, b);
        wait_done(lat, busy_n);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_busy_cycles"}, busy_n, elat);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dz"}, {31'd0, div_zero}, {31'd0, edz});
        @(posedge clock);
        #1;
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, "_q_held"}, quotient, eq);
    endtask

    initial begin
        int lat;
        int busy_n;
        int done_seen;

        reset     = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
        run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
        run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        run_op("u_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        run_op("s_5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        run_op("u20_3_after_dz", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 33);

        // Second start mid-RUN must be ignored.
        drive_start(1'b0, 32'd1000, 32'd10);
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        drive_start(1'b1, 32'd9, 32'd3);
        wait_done(lat, busy_n);
        check("ignored_start_latency", 6 + lat, 33);
        check("ignored_start_q", quotient, 32'd100);
        check("ignored_start_r", remainder, 32'd0);

        // Third start issued in the done cycle is accepted.
        drive_start(1'b0, 32'd50, 32'd7);
        check("b2b_done_dropped", {31'd0, done}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(lat, busy_n);
        check("b2b_latency", lat, 33);
        check("b2b_q", quotient, 32'd7);
        check("b2b_r", remainder, 32'd1);

        // Reset 10 cycles into an operation.
        drive_start(1'b0, 32'd1000, 32'd10);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_q", quotient, 32'd0);
        check("abort_r", remainder, 32'd0);
        check("abort_dz", {31'd0, div_zero}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_idle_q", quotient, 32'd0);
        run_op("u77_5_after_abort", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0, 33);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
